// File: rtl/cpu_pkg.sv
// cpu_pkg: shared width and ALU opcode encodings for the single-bus datapath
package cpu_pkg;
    localparam int WIDTH = 32;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_DIV  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_SHR  = 4'd6;
    localparam logic [3:0] ALU_SHRA = 4'd7;
    localparam logic [3:0] ALU_SHL  = 4'd8;
    localparam logic [3:0] ALU_ROR  = 4'd9;
    localparam logic [3:0] ALU_ROL  = 4'd10;
    localparam logic [3:0] ALU_NEG  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;
    localparam logic [3:0] ALU_INC  = 4'd13;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU producing a 64-bit result for the Z pair
module alu
    import cpu_pkg::*;
(
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);
    logic [4:0] n;
    logic [5:0] m;
    logic [WIDTH-1:0] v, q, r, ror_v, rol_v;
    logic signed [WIDTH-1:0] sq, sr;
    logic [2*WIDTH-1:0] prod;
    assign n = b[4:0];
    assign m = 6'd32 - {1'b0, n};
    assign ror_v = (a >> n) | (a << m);
    assign rol_v = (a << n) | (a >> m);
    assign prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign sq = $signed(a) / $signed(b);
    assign sr = $signed(a) % $signed(b);
    // divide by -1 is special-cased so the most negative dividend wraps instead of trapping
    assign q = (b == '0) ? '0 : (&b) ? -a : sq;
    assign r = (b == '0) ? a : (&b) ? '0 : sr;
    // single-word operations; DIV and MUL bypass this and fill both halves directly
    always_comb begin
        v = b;
        case (op)
            ALU_ADD:  v = a + b;
            ALU_SUB:  v = a - b;
            ALU_AND:  v = a & b;
            ALU_OR:   v = a | b;
            ALU_SHR:  v = a >> n;
            ALU_SHRA: v = $signed(a) >>> n;
            ALU_SHL:  v = a << n;
            ALU_ROR:  v = ror_v;
            ALU_ROL:  v = rol_v;
            ALU_NEG:  v = -b;
            ALU_NOT:  v = ~b;
            ALU_INC:  v = b + 1;
            default:  v = b;
        endcase
    end
    assign result = (op == ALU_DIV) ? {r, q} : (op == ALU_MUL) ? prod : {{WIDTH{v[WIDTH-1]}}, v};
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus CPU datapath with 16 GPRs, special registers and an ALU feeding Z
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ALUcontrol,
    input  logic [WIDTH-1:0] MdataIn,
    input  logic             MDRead,
    input  logic R0Select, R1Select, R2Select, R3Select, R4Select, R5Select, R6Select, R7Select,
    input  logic R8Select, R9Select, R10Select, R11Select, R12Select, R13Select, R14Select, R15Select,
    input  logic HISelect, LOWSelect, ZHighSelect, ZLowSelect, PCSelect, MDRSelect, InPortSelect, COutSelect,
    input  logic IRSelect, RYSelect, RZSelect, MARSelect,
    input  logic R0In, R1In, R2In, R3In, R4In, R5In, R6In, R7In,
    input  logic R8In, R9In, R10In, R11In, R12In, R13In, R14In, R15In,
    input  logic HIIn, LOWIn, PCIn, InPortIn, COutIn, IRIn, RYIn, RZIn, MARIn,
    input  logic ZHighIn, ZLowIn, MDRIn,
    output logic [WIDTH-1:0] BusOut
);
    logic [WIDTH-1:0] gpr [16];
    logic [WIDTH-1:0] src [28];
    logic [WIDTH-1:0] hi, lo, zh, zl, pc, mdr, inport, c, ir, ry, rz, mar, bus;
    logic [2*WIDTH-1:0] result;
    logic [27:0] sel;
    logic [15:0] gpr_in;
    assign sel = {MARSelect, RZSelect, RYSelect, IRSelect, COutSelect, InPortSelect, MDRSelect, PCSelect,
                  ZLowSelect, ZHighSelect, LOWSelect, HISelect,
                  R15Select, R14Select, R13Select, R12Select, R11Select, R10Select, R9Select, R8Select,
                  R7Select, R6Select, R5Select, R4Select, R3Select, R2Select, R1Select, R0Select};
    assign gpr_in = {R15In, R14In, R13In, R12In, R11In, R10In, R9In, R8In,
                     R7In, R6In, R5In, R4In, R3In, R2In, R1In, R0In};
    // bus sources in select-priority order
    always_comb begin
        for (int i = 0; i < 16; i++) src[i] = gpr[i];
        src[16] = hi;
        src[17] = lo;
        src[18] = zh;
        src[19] = zl;
        src[20] = pc;
        src[21] = mdr;
        src[22] = inport;
        src[23] = c;
        src[24] = ir;
        src[25] = ry;
        src[26] = rz;
        src[27] = mar;
    end
    // bus mux: scanning downwards lets the lowest asserted select win
    always_comb begin
        bus = '0;
        for (int i = 27; i >= 0; i--) if (sel[i]) bus = src[i];
    end
    assign BusOut = bus;
    alu u_alu (.op(ALUcontrol), .a(ry), .b(bus), .result(result));
    // register loads from the bus, MDR from its read mux, Z halves from the ALU
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) gpr[i] <= '0;
            {hi, lo, zh, zl, pc, mdr, inport, c, ir, ry, rz, mar} <= '0;
        end else begin
            for (int i = 0; i < 16; i++) if (gpr_in[i]) gpr[i] <= bus;
            if (HIIn) hi <= bus;
            if (LOWIn) lo <= bus;
            if (ZHighIn) zh <= result[2*WIDTH-1:WIDTH];
            if (ZLowIn) zl <= result[WIDTH-1:0];
            if (PCIn) pc <= bus;
            if (MDRIn) mdr <= MDRead ? MdataIn : bus;
            if (InPortIn) inport <= bus;
            if (COutIn) c <= bus;
            if (IRIn) ir <= bus;
            if (RYIn) ry <= bus;
            if (RZIn) rz <= bus;
            if (MARIn) mar <= bus;
        end
    end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed scoreboard bench driving the datapath through its bus strobes
module tb_cpu_datapath;
    localparam int S_HI = 16, S_ZH = 18, S_ZL = 19, S_PC = 20, S_MDR = 21, S_IR = 24, S_RY = 25, S_RZ = 26, S_MAR = 27;
    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    logic clk = 0;
    logic reset = 1;
    logic [3:0] ALUcontrol = '0;
    logic [31:0] MdataIn = '0;
    logic MDRead = 0;
    logic [27:0] sel = '0;
    logic [27:0] ld = '0;
    logic [31:0] BusOut;
    exp_t sb[$];
    int n_asserts = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    cpu_datapath dut (
        .clk(clk), .reset(reset), .ALUcontrol(ALUcontrol), .MdataIn(MdataIn), .MDRead(MDRead),
        .R0Select(sel[0]), .R1Select(sel[1]), .R2Select(sel[2]), .R3Select(sel[3]),
        .R4Select(sel[4]), .R5Select(sel[5]), .R6Select(sel[6]), .R7Select(sel[7]),
        .R8Select(sel[8]), .R9Select(sel[9]), .R10Select(sel[10]), .R11Select(sel[11]),
        .R12Select(sel[12]), .R13Select(sel[13]), .R14Select(sel[14]), .R15Select(sel[15]),
        .HISelect(sel[16]), .LOWSelect(sel[17]), .ZHighSelect(sel[18]), .ZLowSelect(sel[19]),
        .PCSelect(sel[20]), .MDRSelect(sel[21]), .InPortSelect(sel[22]), .COutSelect(sel[23]),
        .IRSelect(sel[24]), .RYSelect(sel[25]), .RZSelect(sel[26]), .MARSelect(sel[27]),
        .R0In(ld[0]), .R1In(ld[1]), .R2In(ld[2]), .R3In(ld[3]),
        .R4In(ld[4]), .R5In(ld[5]), .R6In(ld[6]), .R7In(ld[7]),
        .R8In(ld[8]), .R9In(ld[9]), .R10In(ld[10]), .R11In(ld[11]),
        .R12In(ld[12]), .R13In(ld[13]), .R14In(ld[14]), .R15In(ld[15]),
        .HIIn(ld[16]), .LOWIn(ld[17]), .ZHighIn(ld[18]), .ZLowIn(ld[19]),
        .PCIn(ld[20]), .MDRIn(ld[21]), .InPortIn(ld[22]), .COutIn(ld[23]),
        .IRIn(ld[24]), .RYIn(ld[25]), .RZIn(ld[26]), .MARIn(ld[27]),
        .BusOut(BusOut)
    );
    function automatic logic [27:0] bit_of(int i);
        return 28'(1) << i;
    endfunction
    function automatic logic [63:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sbv, p;
        logic [31:0] v;
        int n;
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        n = int'(b[4:0]);
        v = b;
        case (op)
            4'd0: v = a + b;
            4'd1: v = a - b;
            4'd2: begin
                if (b == 32'h0) return {a, 32'h0};
                return {32'(sa % sbv), 32'(sa / sbv)};
            end
            4'd3: begin
                p = sa * sbv;
                return 64'(p);
            end
            4'd4: v = a & b;
            4'd5: v = a | b;
            4'd6: v = a >> n;
            4'd7: v = 32'($signed(a) >>> n);
            4'd8: v = a << n;
            4'd9: begin
                v = a;
                for (int k = 0; k < n; k++) v = {v[0], v[31:1]};
            end
            4'd10: begin
                v = a;
                for (int k = 0; k < n; k++) v = {v[30:0], v[31]};
            end
            4'd11: v = 32'h0 - b;
            4'd12: v = ~b;
            4'd13: v = b + 32'h1;
            default: v = b;
        endcase
        return {{32{v[31]}}, v};
    endfunction
    task automatic push(string t, logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.v = v;
        sb.push_back(e);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        sel = '0;
        ld = '0;
        MDRead = 0;
    endtask
    task automatic observe(logic [27:0] s);
        exp_t e;
        sel = s;
        #1;
        n_asserts++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: bus %h with no expected entry", BusOut);
        end else begin
            e = sb.pop_front();
            assert (BusOut === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, BusOut, e.v);
            end
        end
        sel = '0;
    endtask
    task automatic load_mdr(logic [31:0] v);
        MdataIn = v;
        MDRead = 1;
        ld = bit_of(S_MDR);
        tick();
    endtask
    task automatic xfer(int s, logic [27:0] d);
        sel = bit_of(s);
        ld = d;
        tick();
    endtask
    task automatic alu_op(logic [31:0] a, logic [31:0] b, logic [3:0] op, string t);
        logic [63:0] r;
        load_mdr(a);
        xfer(S_MDR, bit_of(S_RY));
        load_mdr(b);
        r = model(op, a, b);
        push({t, "_lo"}, r[31:0]);
        push({t, "_hi"}, r[63:32]);
        sel = bit_of(S_MDR);
        ALUcontrol = op;
        ld = bit_of(S_ZL) | bit_of(S_ZH);
        tick();
        observe(bit_of(S_ZL));
        observe(bit_of(S_ZH));
    endtask
    initial begin
        #12;
        push("rst_r0", 32'h0);
        observe(bit_of(0));
        push("rst_pc", 32'h0);
        observe(bit_of(S_PC));
        reset = 0;
        tick();
        push("rst_mdr", 32'h0);
        observe(bit_of(S_MDR));
        load_mdr(32'hC);
        push("mdr_load", 32'hC);
        observe(bit_of(S_MDR));
        xfer(S_MDR, bit_of(2));
        load_mdr(32'h4);
        xfer(S_MDR, bit_of(3));
        load_mdr(32'h8);
        xfer(S_MDR, bit_of(4));
        push("r2", 32'hC);
        observe(bit_of(2));
        push("r3", 32'h4);
        observe(bit_of(3));
        push("r4", 32'h8);
        observe(bit_of(4));
        xfer(2, bit_of(S_RY));
        push("div_lo", 32'h3);
        push("div_hi", 32'h0);
        sel = bit_of(3);
        ALUcontrol = 4'b0010;
        ld = bit_of(S_ZL) | bit_of(S_ZH);
        tick();
        observe(bit_of(S_ZL));
        observe(bit_of(S_ZH));
        xfer(S_ZL, bit_of(5));
        push("r5_from_z", 32'h3);
        observe(bit_of(5));
        load_mdr(32'h4A920000);
        xfer(S_MDR, bit_of(S_IR) | bit_of(S_PC));
        push("ir", 32'h4A920000);
        observe(bit_of(S_IR));
        push("pc", 32'h4A920000);
        observe(bit_of(S_PC));
        alu_op(32'hFFFFFFFF, 32'h3, 4'd3, "mul");
        alu_op(32'h4, 32'h8, 4'd1, "sub");
        alu_op(32'h0, 32'h1, 4'd11, "neg");
        alu_op(32'h5, 32'h0, 4'd2, "div0");
        alu_op(32'hFFFFFFF9, 32'h2, 4'd2, "div_neg");
        alu_op(32'h80000000, 32'hFFFFFFFF, 4'd2, "div_ovf");
        alu_op(32'h7FFFFFFF, 32'h1, 4'd0, "add_wrap");
        alu_op(32'h12345678, 32'h00007654, 4'd3, "mul_pos");
        alu_op(32'hF0F0F0F0, 32'h0FF00FF0, 4'd4, "and");
        alu_op(32'hF0F0F0F0, 32'h0FF00FF0, 4'd5, "or");
        alu_op(32'h80000010, 32'h24, 4'd6, "shr");
        alu_op(32'h80000010, 32'h4, 4'd7, "shra");
        alu_op(32'h80000011, 32'h1F, 4'd8, "shl");
        alu_op(32'h80000001, 32'h4, 4'd9, "ror");
        alu_op(32'h80000001, 32'h4, 4'd10, "rol");
        alu_op(32'h0, 32'h0000FFFF, 4'd12, "not");
        alu_op(32'h0, 32'h7FFFFFFF, 4'd13, "inc");
        alu_op(32'h55, 32'h80000000, 4'd14, "pass14");
        alu_op(32'h55, 32'h00001234, 4'd15, "pass15");
        push("zlow_only_lo", 32'hFFFFEDCC);
        push("zlow_only_hi_hold", 32'h0);
        sel = bit_of(S_MDR);
        ALUcontrol = 4'd11;
        ld = bit_of(S_ZL);
        tick();
        observe(bit_of(S_ZL));
        observe(bit_of(S_ZH));
        load_mdr(32'h11);
        xfer(S_MDR, bit_of(1));
        push("prio_r1_r5", 32'h11);
        observe(bit_of(1) | bit_of(5));
        push("prio_hi_mar", 32'h0);
        observe(bit_of(S_HI) | bit_of(S_MAR));
        push("no_select", 32'h0);
        observe('0);
        MdataIn = 32'hDEADBEEF;
        MDRead = 0;
        sel = bit_of(5);
        ld = bit_of(S_MDR);
        tick();
        push("mdr_from_bus", 32'h3);
        observe(bit_of(S_MDR));
        sel = bit_of(1);
        ld = bit_of(7) | bit_of(S_RZ) | bit_of(S_MAR) | bit_of(1);
        tick();
        push("multi_r7", 32'h11);
        observe(bit_of(7));
        push("multi_rz", 32'h11);
        observe(bit_of(S_RZ));
        push("multi_mar", 32'h11);
        observe(bit_of(S_MAR));
        @(negedge clk);
        reset = 1;
        push("async_rst_r1", 32'h0);
        observe(bit_of(1));
        push("async_rst_ir", 32'h0);
        observe(bit_of(S_IR));
        push("async_rst_zlow", 32'h0);
        observe(bit_of(S_ZL));
        push("async_rst_mdr", 32'h0);
        observe(bit_of(S_MDR));
        reset = 0;
        tick();
        push("post_rst_r4", 32'h0);
        observe(bit_of(4));
        n_asserts++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
